dma_desc_arbiter: RTL and testbench
===================================

Name: dma_desc_arbiter

Overview:
Shares one DMA descriptor-controller slave (DCS) between two show-ahead request FIFOs, for example an admin queue and an I/O queue. On each grant it pops one 116-bit request and writes it to the DCS as a 5-word descriptor, then re-arbitrates. Grants alternate round-robin between the two requesters. A credit counter, decremented by DMA completion pulses, caps the number of descriptors in flight.

Parameters:
MAX_OUTSTANDING, 4, maximum issued-but-not-completed descriptors (1..15)
STATUS_ADDR, 64'h6000, 64-bit status write-back address placed in every descriptor

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-low reset
Req0Empty  in  1  requester 0 FIFO empty
Req0Data  in  116  requester 0 FIFO head (show-ahead)
Req0Pop  out  1  requester 0 pop, one-cycle pulse
Req1Empty  in  1  requester 1 FIFO empty
Req1Data  in  116  requester 1 FIFO head
Req1Pop  out  1  requester 1 pop, one-cycle pulse
DCSChipSelect  out  1  Avalon-MM chipselect
DCSWrite  out  1  Avalon-MM write
DCSAddress  out  8  byte address of descriptor word
DCSWriteData  out  32  descriptor word
DCSByteEnable  out  4  byte enables, constant 4'hf
DCSRead  out  1  constant 0
DCSWaitRequest  in  1  slave stall
DCSReadData  in  32  unused
DmaDoneValid  in  1  one-cycle pulse per completed descriptor
Outstanding  out  4  current in-flight count
GrantId  out  1  requester owning the current or last descriptor
CreditUnderflow  out  1  sticky error flag

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, Outstanding=0, round-robin pointer=0, GrantId=0, CreditUnderflow=0.
  - All pops, DCSWrite and DCSChipSelect are 0.
  - Reset mid-descriptor abandons the remaining words; no pop is reissued.
- States: IDLE, WRITE.
- IDLE: eligible = requester non-empty AND Outstanding < MAX_OUTSTANDING.
  - Both eligible: grant the pointer's requester.
  - One eligible: grant it.
  - On grant, in the same cycle:
    - latch its Data into a 116-bit hold register;
    - pulse its Pop;
    - set GrantId;
    - set pointer = ~granted id;
    - Outstanding += 1;
    - word counter = 0;
    - next state WRITE.
- WRITE:
  - DCSWrite = DCSChipSelect = 1.
  - DCSAddress = {3'd0, wordcnt, 2'd0}, giving 0x00, 0x04, 0x08, 0x0C, 0x10.
  - A word is accepted on a cycle with DCSWrite=1 and DCSWaitRequest=0; wordcnt then increments.
  - Address and data stay stable while DCSWaitRequest=1.
  - Acceptance of word 4 (the doorbell) returns to IDLE.
  - IDLE may grant again on that next cycle, giving a minimum of one idle cycle between descriptors.
- Descriptor words (H = hold register):
  - w0 = STATUS_ADDR[31:0]
  - w1 = STATUS_ADDR[63:32]
  - w2 = H[31:0]
  - w3 = H[63:32]
  - w4 = {29'd0, H[110:108] - 3'd1}; the 3-bit subtract wraps, so a length of 0 yields 3'd7.
- Latency: requester non-empty in IDLE at cycle N -> Pop at N -> w0 on bus at N+1 -> w4 no earlier than N+5.
- Credits:
  - DmaDoneValid decrements Outstanding.
  - A grant and DmaDoneValid in the same cycle leave Outstanding unchanged.
  - DmaDoneValid with Outstanding==0 (and no simultaneous grant): Outstanding stays 0 and CreditUnderflow sets; it is cleared only by reset.
  - Outstanding==MAX_OUTSTANDING blocks grants. A DmaDoneValid in cycle N allows a grant in cycle N+1, not in N.
- Pops are never asserted outside an IDLE->WRITE transition. At most one Pop is high per cycle.
- Req*Data changes after a pop do not affect the descriptor in flight.

Test Plan:
1. Req0 only, Data[63:0]=64'h0000_0001_2345_6780, Data[110:108]=3'd4, no waitrequest -> Req0Pop at N; writes at N+1..N+5 of 0x6000, 0x0, 0x23456780, 0x1, 0x3 to addresses 0x00..0x10; Outstanding=1.
2. Both FIFOs hold 3 entries, MAX=8, DmaDoneValid held off -> grants 0,1,0,1,0,1; each descriptor carries its own requester's data; Outstanding=6.
3. DCSWaitRequest=1 for 3 cycles during w2 -> address 0x08 and its data held for 4 cycles; total descriptor time 8 cycles; single Pop.
4. MAX=2, two descriptors issued, third request pending -> no grant. DmaDoneValid at N -> grant at N+1. Done coinciding with a grant -> Outstanding unchanged.
5. Length field 3'd0 -> w4 = 0x00000007. DmaDoneValid with Outstanding=0 -> CreditUnderflow=1 until reset.
6. reset=0 during w3 -> next cycle DCSWrite=0, Outstanding=0; after release a fresh request starts at w0 with pointer=0.

Source files
------------

// File: rtl/dma_desc_arbiter.sv
// rtl/dma_desc_arbiter.sv - round-robin arbiter feeding 5-word descriptors to a DMA descriptor slave
module dma_desc_arbiter #(
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [63:0] STATUS_ADDR     = 64'h6000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         Req0Empty,
    input  logic [115:0] Req0Data,
    output logic         Req0Pop,
    input  logic         Req1Empty,
    input  logic [115:0] Req1Data,
    output logic         Req1Pop,
    output logic         DCSChipSelect,
    output logic         DCSWrite,
    output logic [7:0]   DCSAddress,
    output logic [31:0]  DCSWriteData,
    output logic [3:0]   DCSByteEnable,
    output logic         DCSRead,
    input  logic         DCSWaitRequest,
    input  logic [31:0]  DCSReadData,
    input  logic         DmaDoneValid,
    output logic [3:0]   Outstanding,
    output logic         GrantId,
    output logic         CreditUnderflow
);

    typedef enum logic {IDLE, WRITE} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    state_t       state, state_nxt;
    logic [115:0] hold;
    logic [2:0]   wordcnt;
    logic [3:0]   outstanding;
    logic         rr_ptr;
    logic         grant_id;
    logic         underflow;

    logic         credit_ok;
    logic         elig0, elig1;
    logic         grant;
    logic         grant_sel;
    logic         word_accept;

    // Only the length field and the 64-bit address of the hold register reach the bus
    logic         unused_bits;
    assign unused_bits = ^{DCSReadData, hold[115:111], hold[107:64]};

    assign credit_ok = (outstanding < MAX_CNT);
    assign elig0     = !Req0Empty && credit_ok;
    assign elig1     = !Req1Empty && credit_ok;

    // Next-state and grant decision; grants are suppressed while reset is asserted
    always_comb begin
        state_nxt   = state;
        grant       = 1'b0;
        grant_sel   = 1'b0;
        word_accept = 1'b0;
        case (state)
            IDLE: begin
                if (reset && (elig0 || elig1)) begin
                    grant     = 1'b1;
                    grant_sel = (elig0 && elig1) ? rr_ptr : elig1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                word_accept = !DCSWaitRequest;
                if (word_accept && wordcnt == 3'd4) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Descriptor word selection; the length field is sent minus one with 3-bit wrap
    always_comb begin
        DCSWriteData = 32'd0;
        case (wordcnt)
            3'd0:    DCSWriteData = STATUS_ADDR[31:0];
            3'd1:    DCSWriteData = STATUS_ADDR[63:32];
            3'd2:    DCSWriteData = hold[31:0];
            3'd3:    DCSWriteData = hold[63:32];
            default: DCSWriteData = {29'd0, hold[110:108] - 3'd1};
        endcase
    end

    assign Req0Pop         = grant && !grant_sel;
    assign Req1Pop         = grant && grant_sel;
    assign DCSWrite        = (state == WRITE);
    assign DCSChipSelect   = (state == WRITE);
    assign DCSAddress      = {3'd0, wordcnt, 2'd0};
    assign DCSByteEnable   = 4'hf;
    assign DCSRead         = 1'b0;
    assign Outstanding     = outstanding;
    assign GrantId         = grant_id;
    assign CreditUnderflow = underflow;

    // State, hold register, word counter, round-robin pointer and credit tracking
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            hold        <= '0;
            wordcnt     <= 3'd0;
            outstanding <= 4'd0;
            rr_ptr      <= 1'b0;
            grant_id    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                hold     <= grant_sel ? Req1Data : Req0Data;
                grant_id <= grant_sel;
                rr_ptr   <= ~grant_sel;
                wordcnt  <= 3'd0;
            end else if (word_accept) begin
                wordcnt <= wordcnt + 3'd1;
            end
            case ({grant, DmaDoneValid})
                2'b10: outstanding <= outstanding + 4'd1;
                2'b01: begin
                    if (outstanding == 4'd0) begin
                        underflow <= 1'b1;
                    end else begin
                        outstanding <= outstanding - 4'd1;
                    end
                end
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_desc_arbiter.sv
// tb/tb_dma_desc_arbiter.sv - randomized scoreboard bench for dma_desc_arbiter
module tb_dma_desc_arbiter;

    localparam int          MAX = 3;
    localparam logic [63:0] SA  = 64'h6000;

    logic         clock = 1'b0;
    logic         reset;
    logic         Req0Empty, Req1Empty;
    logic [115:0] Req0Data, Req1Data;
    logic         Req0Pop, Req1Pop;
    logic         DCSChipSelect, DCSWrite, DCSRead;
    logic [7:0]   DCSAddress;
    logic [31:0]  DCSWriteData, DCSReadData;
    logic [3:0]   DCSByteEnable;
    logic         DCSWaitRequest;
    logic         DmaDoneValid;
    logic [3:0]   Outstanding;
    logic         GrantId;
    logic         CreditUnderflow;

    dma_desc_arbiter #(.MAX_OUTSTANDING(MAX), .STATUS_ADDR(SA)) dut (
        .clock(clock), .reset(reset),
        .Req0Empty(Req0Empty), .Req0Data(Req0Data), .Req0Pop(Req0Pop),
        .Req1Empty(Req1Empty), .Req1Data(Req1Data), .Req1Pop(Req1Pop),
        .DCSChipSelect(DCSChipSelect), .DCSWrite(DCSWrite), .DCSAddress(DCSAddress),
        .DCSWriteData(DCSWriteData), .DCSByteEnable(DCSByteEnable), .DCSRead(DCSRead),
        .DCSWaitRequest(DCSWaitRequest), .DCSReadData(DCSReadData),
        .DmaDoneValid(DmaDoneValid), .Outstanding(Outstanding),
        .GrantId(GrantId), .CreditUnderflow(CreditUnderflow)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } word_t;

    logic [115:0] q0[$];
    logic [115:0] q1[$];
    word_t        expq[$];

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_out       = 0;
    bit m_ptr       = 0;
    bit m_gid       = 0;
    bit m_uf        = 0;
    bit m_valid     = 0;
    int words_left  = 0;
    int grants_seen = 0;
    int uf_seen     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [115:0] rand_req();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[115:0];
    endfunction

    function automatic logic [31:0] len_word(input logic [115:0] d);
        int len;
        len = int'(d[110:108]);
        return 32'((len + 7) % 8);
    endfunction

    // Reference model: decides expected grants and credits, queues expected bus words
    initial begin
        logic         want;
        logic         sel;
        logic         e0, e1;
        logic [115:0] d;
        forever begin
            @(negedge clock);
            if (m_valid) begin
                check("outstanding", Outstanding, m_out);
                check("grant_id", GrantId, m_gid);
                check("underflow", CreditUnderflow, m_uf);
                check("dcs_write", DCSWrite, words_left > 0);
                check("dcs_cs", DCSChipSelect, words_left > 0);
                check("dcs_be", DCSByteEnable, 4'hf);
                check("dcs_read", DCSRead, 0);
            end
            e0 = (q0.size() > 0) && (m_out < MAX);
            e1 = (q1.size() > 0) && (m_out < MAX);
            want = reset && m_valid && (words_left == 0) && (e0 || e1);
            sel  = (e0 && e1) ? m_ptr : e1;
            check("pops", {Req1Pop, Req0Pop}, want ? (sel ? 2'b10 : 2'b01) : 2'b00);
            if (!reset) begin
                m_out = 0; m_ptr = 0; m_gid = 0; m_uf = 0;
                words_left = 0;
                expq.delete();
                m_valid = 1;
            end else begin
                if (words_left > 0 && !DCSWaitRequest) words_left--;
                if (want) begin
                    d = sel ? q1.pop_front() : q0.pop_front();
                    expq.push_back('{8'h00, SA[31:0]});
                    expq.push_back('{8'h04, SA[63:32]});
                    expq.push_back('{8'h08, d[31:0]});
                    expq.push_back('{8'h0C, d[63:32]});
                    expq.push_back('{8'h10, len_word(d)});
                    words_left = 5;
                    m_ptr = !sel;
                    m_gid = sel;
                    grants_seen++;
                end
                if (want && !DmaDoneValid) m_out++;
                else if (!want && DmaDoneValid) begin
                    if (m_out == 0) begin
                        m_uf = 1;
                        uf_seen++;
                    end else m_out--;
                end
            end
        end
    end

    // Bus monitor: every accepted or stalled word is compared with the scoreboard head
    initial begin
        word_t e;
        forever begin
            @(negedge clock);
            if (reset && DCSWrite) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write", DCSAddress, DCSWriteData);
                end else if (DCSWaitRequest) begin
                    e = expq[0];
                    check("held_addr", DCSAddress, e.a);
                    check("held_data", DCSWriteData, e.d);
                end else begin
                    e = expq.pop_front();
                    check("word_addr", DCSAddress, e.a);
                    check("word_data", DCSWriteData, e.d);
                end
            end
        end
    end

    // Stimulus: random FIFO fills, stalls, completions and resets landing on w3
    initial begin
        int phase;
        int rst_cnt;
        logic [115:0] first;
        rst_cnt = 0;
        reset = 1'b0;
        Req0Empty = 1'b1; Req1Empty = 1'b1;
        Req0Data = '0; Req1Data = '0;
        DCSWaitRequest = 1'b0; DCSReadData = 32'hdead_beef;
        DmaDoneValid = 1'b0;
        first = rand_req();
        first[63:0] = 64'h0000_0001_2345_6780;
        first[110:108] = 3'd4;
        q0.push_back(first);
        first = rand_req();
        first[110:108] = 3'd0;
        q1.push_back(first);
        repeat (2) @(posedge clock);
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(posedge clock);
            #1;
            phase = (cyc / 400) % 3;
            if (rst_cnt > 0) rst_cnt--;
            else if (cyc > 50 && words_left == 2 && $urandom_range(0, 29) == 0)
                rst_cnt = $urandom_range(1, 2);
            reset = (rst_cnt == 0);
            if (cyc > 8) begin
                if (q0.size() < 3 && $urandom_range(0, 3) == 0) q0.push_back(rand_req());
                if (q1.size() < 3 && $urandom_range(0, 3) == 0) q1.push_back(rand_req());
            end
            DCSWaitRequest = (cyc > 8) && ($urandom_range(0, 2) == 0);
            case (phase)
                0:       DmaDoneValid = 1'b0;
                1:       DmaDoneValid = ($urandom_range(0, 9) == 0);
                default: DmaDoneValid = ($urandom_range(0, 2) == 0);
            endcase
            Req0Empty = (q0.size() == 0);
            Req1Empty = (q1.size() == 0);
            Req0Data  = Req0Empty ? rand_req() : q0[0];
            Req1Data  = Req1Empty ? rand_req() : q1[0];
        end
        @(negedge clock);
        check("grant_activity", grants_seen >= 100, 1);
        check("underflow_activity", uf_seen > 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
